// File: rtl/compressed_pkg.sv
// Shared types for the decode-side RVC realigner: FSM state, case flags and the
// encoding of a full (32-bit) instruction's low bits.
package compressed_pkg;

  typedef enum logic [1:0] {
    ALIGNED,
    SPLIT,
    UPPER_C,
    SKIP_LOW
  } align_state_e;

  typedef struct packed {
    logic f1f1;
    logic f1f2;
    logic hf;
    logic fh;
    logic hh;
  } align_case_t;

  localparam logic [1:0] RVC_FULL = 2'b11;

endpackage

// File: rtl/rvc_half_classify.sv
// Classifies one 16-bit half of a fetch word as the start of a 32-bit
// instruction (full) or a 16-bit RVC instruction (compressed).
module rvc_half_classify
  import compressed_pkg::*;
(
  input  logic [15:0] half,
  output logic        full,
  output logic        compressed
);

  // Only the two opcode bits decide the length.
  logic unused_hi;
  assign unused_hi = ^half[15:2];

  assign full       = (half[1:0] == RVC_FULL);
  assign compressed = ~full;

endmodule

// File: rtl/compressed_aligner.sv
// Realigns fetch words into 32-bit and RVC instructions for decode, with the
// case flags consumed by PC correction. RVC support is built only when
// COMPRESSED_EN is defined; otherwise every word passes through as f1f1.
module compressed_aligner
  import compressed_pkg::*;
#(
  parameter int unsigned PC_W    = 32,
  parameter logic [15:0] BUF_RST = 16'h0000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [31:0]     fetch_word,
  input  logic [PC_W-1:0] fetch_pc,
  input  logic            fetch_valid,
  input  logic            id_ready,
  input  logic            flush,
  input  logic            flush_pc1,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] instr_pc,
  output logic            instr_valid,
  output logic            is_compressed,
  output logic            f1f1,
  output logic            f1f2,
  output logic            hf,
  output logic            fh,
  output logic            hh,
  output logic            stall_compressed
);

  logic [PC_W-1:0] pc_base;
  logic            gate;
  logic            raw_valid;
  logic [31:0]     raw_instr;
  logic [PC_W-1:0] raw_pc;
  logic            raw_comp;
  align_case_t     raw_case;
  logic            raw_stall;

  assign pc_base = {fetch_pc[PC_W-1:2], 1'b0, fetch_pc[0]};
  assign gate    = fetch_valid & ~flush & reset_n;

`ifdef COMPRESSED_EN
  align_state_e state_q, state_d;
  logic [15:0]  buf_q, buf_d;
  logic         l_full, l_comp, u_full, u_comp;

  logic unused;
  assign unused = ^{fetch_pc[1], l_comp};

  rvc_half_classify u_cls_lo (
    .half       (fetch_word[15:0]),
    .full       (l_full),
    .compressed (l_comp)
  );

  rvc_half_classify u_cls_hi (
    .half       (fetch_word[31:16]),
    .full       (u_full),
    .compressed (u_comp)
  );

  always_comb begin
    raw_valid = 1'b0;
    raw_instr = '0;
    raw_pc    = pc_base;
    raw_comp  = 1'b0;
    raw_case  = '0;
    raw_stall = 1'b0;
    state_d   = state_q;
    buf_d     = buf_q;
    unique case (state_q)
      ALIGNED: begin
        raw_valid = 1'b1;
        if (l_full) begin
          raw_instr     = fetch_word;
          raw_case.f1f1 = 1'b1;
        end else begin
          raw_instr = {16'h0000, fetch_word[15:0]};
          raw_comp  = 1'b1;
          if (u_comp) begin
            raw_case.hh = 1'b1;
            raw_stall   = 1'b1;
            state_d     = UPPER_C;
          end else begin
            raw_case.hf = 1'b1;
            buf_d       = fetch_word[31:16];
            state_d     = SPLIT;
          end
        end
      end
      SPLIT: begin
        raw_valid = 1'b1;
        raw_instr = {fetch_word[15:0], buf_q};
        raw_pc    = pc_base - PC_W'(2);
        if (u_full) begin
          raw_case.f1f2 = 1'b1;
          buf_d         = fetch_word[31:16];
        end else begin
          raw_case.fh = 1'b1;
          raw_stall   = 1'b1;
          state_d     = UPPER_C;
        end
      end
      UPPER_C: begin
        raw_valid   = 1'b1;
        raw_instr   = {16'h0000, fetch_word[31:16]};
        raw_pc      = pc_base + PC_W'(2);
        raw_comp    = 1'b1;
        raw_case.hh = 1'b1;
        state_d     = ALIGNED;
      end
      SKIP_LOW: begin
        // Redirect landed on the upper half; a full upper half only starts a split.
        if (u_full) begin
          buf_d   = fetch_word[31:16];
          state_d = SPLIT;
        end else begin
          raw_valid   = 1'b1;
          raw_instr   = {16'h0000, fetch_word[31:16]};
          raw_pc      = pc_base + PC_W'(2);
          raw_comp    = 1'b1;
          raw_case.hh = 1'b1;
          state_d     = ALIGNED;
        end
      end
      default: ;
    endcase
    if (flush) begin
      state_d = flush_pc1 ? SKIP_LOW : ALIGNED;
      buf_d   = BUF_RST;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ALIGNED;
      buf_q   <= BUF_RST;
    end else if (flush || (fetch_valid && id_ready)) begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end
`else
  logic unused;
  assign unused = ^{clk, id_ready, flush_pc1, fetch_pc[1], BUF_RST};

  always_comb begin
    raw_valid     = 1'b1;
    raw_instr     = fetch_word;
    raw_pc        = pc_base;
    raw_comp      = 1'b0;
    raw_case      = '0;
    raw_case.f1f1 = 1'b1;
    raw_stall     = 1'b0;
  end
`endif

  assign instr_valid      = gate & raw_valid;
  assign instr            = instr_valid ? raw_instr : '0;
  assign instr_pc         = instr_valid ? raw_pc : '0;
  assign is_compressed    = instr_valid & raw_comp;
  assign {f1f1, f1f2, hf, fh, hh} = instr_valid ? raw_case : '0;
  assign stall_compressed = gate & raw_stall;

endmodule

// File: tb/tb_compressed_aligner.sv
// Self-checking bench for compressed_aligner against a half-word stream model;
// honours COMPRESSED_EN the same way the design does.
module tb_compressed_aligner;

  localparam int unsigned PcW = 32;
`ifdef COMPRESSED_EN
  localparam bit Comp = 1'b1;
`else
  localparam bit Comp = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n;
  logic [31:0]    fetch_word;
  logic [PcW-1:0] fetch_pc;
  logic           fetch_valid, id_ready, flush, flush_pc1;
  logic [31:0]    instr;
  logic [PcW-1:0] instr_pc;
  logic           instr_valid, is_compressed, f1f1, f1f2, hf, fh, hh, stall_compressed;

  int n_checks = 0;
  int n_errors = 0;

  // Model: carried low half of a straddling instruction, and whether the next
  // instruction starts at the upper half of the presented word.
  logic        m_carry_v, m_off;
  logic [15:0] m_carry;
  logic [71:0] got, exp;

  always #5 clk = ~clk;

  compressed_aligner #(.PC_W(PcW), .BUF_RST(16'h0000)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .fetch_word       (fetch_word),
    .fetch_pc         (fetch_pc),
    .fetch_valid      (fetch_valid),
    .id_ready         (id_ready),
    .flush            (flush),
    .flush_pc1        (flush_pc1),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_valid      (instr_valid),
    .is_compressed    (is_compressed),
    .f1f1             (f1f1),
    .f1f2             (f1f2),
    .hf               (hf),
    .fh               (fh),
    .hh               (hh),
    .stall_compressed (stall_compressed)
  );

  assign got = {instr_valid, instr, instr_pc, is_compressed, f1f1, f1f2, hf, fh, hh,
                stall_compressed};

  // Expected {valid, instr, pc, is_c, f1f1 f1f2 hf fh hh, stall}.
  function automatic logic [71:0] model_out();
    logic [15:0] lo, hi;
    logic        lf, uf, v, isc, st;
    logic [31:0] ins, pc, base;
    logic [4:0]  fl;
    lo = fetch_word[15:0];
    hi = fetch_word[31:16];
    lf = (lo[1:0] == 2'b11);
    uf = (hi[1:0] == 2'b11);
    base = fetch_pc & ~32'h2;
    v = 0; isc = 0; st = 0; ins = 0; pc = 0; fl = 0;
    if (reset_n && fetch_valid && !flush) begin
      if (!Comp) begin
        v = 1; ins = fetch_word; pc = base; fl = 5'b10000;
      end else if (m_carry_v) begin
        v = 1; ins = {lo, m_carry}; pc = base - 32'd2;
        if (uf) fl = 5'b01000;
        else begin fl = 5'b00010; st = 1; end
      end else if (m_off) begin
        if (!uf) begin v = 1; ins = {16'h0, hi}; pc = base + 32'd2; isc = 1; fl = 5'b00001; end
      end else if (lf) begin
        v = 1; ins = fetch_word; pc = base; fl = 5'b10000;
      end else begin
        v = 1; ins = {16'h0, lo}; pc = base; isc = 1;
        if (uf) fl = 5'b00100;
        else begin fl = 5'b00001; st = 1; end
      end
    end
    return {v, ins, pc, isc, fl, st};
  endfunction

  task automatic model_reset();
    m_carry_v = 0; m_off = 0; m_carry = 16'h0;
  endtask

  task automatic model_step();
    logic lf, uf;
    lf = (fetch_word[1:0] == 2'b11);
    uf = (fetch_word[17:16] == 2'b11);
    if (flush) begin
      m_carry_v = 0; m_off = Comp && flush_pc1;
    end else if (fetch_valid && id_ready && Comp) begin
      if (m_carry_v) begin
        if (uf) m_carry = fetch_word[31:16];
        else begin m_carry_v = 0; m_off = 1; end
      end else if (m_off) begin
        if (uf) begin m_carry_v = 1; m_carry = fetch_word[31:16]; end
        m_off = 0;
      end else if (!lf) begin
        if (uf) begin m_carry_v = 1; m_carry = fetch_word[31:16]; end
        else m_off = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic drive(input logic [31:0] w, input logic [31:0] p, input logic fv,
                       input logic rdy, input logic fl, input logic fp1);
    fetch_word = w; fetch_pc = p; fetch_valid = fv; id_ready = rdy;
    flush = fl; flush_pc1 = fp1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom();
    if ($urandom_range(0, 1) == 1) w[1:0] = 2'b11;
    if ($urandom_range(0, 1) == 1) w[17:16] = 2'b11;
    return w;
  endfunction

  task automatic test_reset();
    reset_n = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) reset_n = 1;
      drive(32'h00934505, 32'h100, (i == 0), 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      exp = model_out();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL reset step %0d: got=%h exp=%h", i, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_aligned32();
    logic [31:0] ws [2];
    ws = '{32'h00A00093, 32'h00B00113};
    for (int i = 0; i < 2; i++) begin
      drive(ws[i], 32'h100 + 32'(4 * i), 1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      exp = model_out();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL aligned32 step %0d: got=%h exp=%h", i, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_two_cli();
    for (int i = 0; i < 2; i++) begin
      drive(32'h45854505, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      exp = model_out();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL two_cli step %0d: got=%h exp=%h", i, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_straddle();
    logic [31:0] ws [3];
    logic [31:0] ps [3];
    ws = '{32'h00934505, 32'h458500A0, 32'h458500A0};
    ps = '{32'h300, 32'h304, 32'h304};
    for (int i = 0; i < 3; i++) begin
      drive(ws[i], ps[i], 1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      exp = model_out();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL straddle step %0d: got=%h exp=%h", i, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_split_chain();
    logic [31:0] ws [5];
    logic [31:0] ps [5];
    ws = '{32'h00934505, 32'h009300A0, 32'h009300A0, 32'h458500A0, 32'h458500A0};
    ps = '{32'h600, 32'h604, 32'h608, 32'h60C, 32'h60C};
    for (int i = 0; i < 10; i++) begin
      drive(ws[i / 2], ps[i / 2], 1'b1, (i % 2 == 1), 1'b0, 1'b0);
      @(negedge clk);
      exp = model_out();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL split_chain step %0d: got=%h exp=%h", i, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_fetch_invalid();
    logic [31:0] ws [6];
    logic [31:0] ps [6];
    logic        fvs [6];
    ws  = '{32'h00934505, 32'h458500A0, 32'h458500A0, 32'h458500A0, 32'h458500A0,
            32'h458500A0};
    ps  = '{32'h700, 32'h704, 32'h704, 32'h704, 32'h704, 32'h704};
    fvs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(ws[i], ps[i], fvs[i], 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      exp = model_out();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL fetch_invalid step %0d: got=%h exp=%h", i, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    logic [31:0] ws [7];
    logic [31:0] ps [7];
    logic        fls [7];
    logic        fp1s [7];
    ws   = '{32'h12345678, 32'h00934505, 32'h458500A0, 32'h458500A0, 32'h45854505,
             32'h45854505, 32'h00B00113};
    ps   = '{32'h3FC, 32'h400, 32'h404, 32'h404, 32'h408, 32'h408, 32'h800};
    fls  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    fp1s = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      drive(ws[i], ps[i], 1'b1, (i != 0), fls[i], fp1s[i]);
      @(negedge clk);
      exp = model_out();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL flush step %0d: got=%h exp=%h", i, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] ws [3];
    logic [31:0] ps [3];
    ws = '{32'h00934505, 32'h458500A0, 32'h458500A0};
    ps = '{32'hFFFF_FFFC, 32'h0, 32'h0};
    for (int i = 0; i < 3; i++) begin
      drive(ws[i], ps[i], 1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      exp = model_out();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL pc_wrap step %0d: got=%h exp=%h", i, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(32'h00934505, 32'h500, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h458500A0, 32'h504, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    exp = model_out();
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL async_reset split: got=%h exp=%h", got, exp);
    end
    #2 reset_n = 0;
    model_reset();
    #1;
    exp = model_out();
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL async_reset mid: got=%h exp=%h", got, exp);
    end
    tick();
    #2 reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) drive(32'h00B00113, 32'h508, 1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      exp = model_out();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL async_reset after step %0d: got=%h exp=%h", i, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] cur_w, cur_pc;
    logic        fv, rdy, fl, fp1;
    cur_w  = rand_word();
    cur_pc = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      fv  = ($urandom_range(0, 9) < 8);
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 19) == 0);
      fp1 = 1'($urandom_range(0, 1));
      drive(cur_w, cur_pc, fv, rdy, fl, fp1);
      @(negedge clk);
      exp = model_out();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL random cycle %0d: got=%h exp=%h", i, got, exp);
      end
      // Fetch re-presents the same word while a stall is requested.
      if (fl) begin
        cur_pc = $urandom() & 32'hFFFF_FFFC;
        cur_w  = rand_word();
      end else if (fv && rdy && !exp[0]) begin
        cur_pc = cur_pc + 32'd4;
        cur_w  = rand_word();
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    reset_n = 0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    test_reset();
    test_aligned32();
    test_two_cli();
    test_straddle();
    test_split_chain();
    test_fetch_invalid();
    test_flush();
    test_pc_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/compressed_aligner.md
Name: compressed_aligner

Overview:
- Decode-side realigner between the IF/ID register and the decoder. It sits directly upstream of the PC-correction logic.
- Splits each 32-bit fetch word into 32-bit and 16-bit (RVC) instructions.
- Buffers a dangling lower half when a 32-bit instruction straddles two fetch words.
- Emits one instruction per cycle plus the one-hot case flags f1f1, f1f2, hf, fh, hh and stall_compressed, which the PC corrector consumes.

Parameters:
- PC_W, 32, width of PC and fetch-PC buses.
- BUF_RST, 16'h0000, reset/flush value of the half-word buffer.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- fetch_word  in  32  word from the IF/ID register.
- fetch_pc  in  PC_W  word-aligned address of fetch_word; bit 1 is ignored.
- fetch_valid  in  1  fetch_word is valid.
- id_ready  in  1  decode accepts an instruction this cycle.
- flush  in  1  redirect (branch, jump, trap); synchronous clear.
- flush_pc1  in  1  bit 1 of the redirect target, sampled with flush.
- instr  out  32  aligned instruction; compressed instructions are zero-extended in [15:0].
- instr_pc  out  PC_W  PC of instr.
- instr_valid  out  1  instr valid this cycle.
- is_compressed  out  1  instr is a 16-bit instruction.
- f1f1, f1f2, hf, fh, hh  out  1 each  one-hot case flags; all 0 when instr_valid=0.
- stall_compressed  out  1  hold the fetch word; the same word is presented again next cycle.

Behaviour:
- All outputs are combinational from the state register, the buffer and the current fetch_word. There is zero latency.
- State and buffer advance on posedge clk only when fetch_valid & id_ready & ~flush. Otherwise they hold.
- Define full(x) as x[1:0]==2'b11. L = fetch_word[15:0], U = fetch_word[31:16].
- Reset (reset_n=0, asynchronous):
  - state=ALIGNED, buf=BUF_RST.
  - With fetch_valid=0 all outputs are 0.
- State ALIGNED:
  - full(L): emit fetch_word, f1f1, pc=fetch_pc, stay.
  - !full(L) & !full(U): emit L compressed, hh, stall_compressed=1, pc=fetch_pc, go to UPPER_C.
  - !full(L) & full(U): emit L compressed, hf, pc=fetch_pc, buf<=U, go to SPLIT.
- State SPLIT (buf holds the low half of a 32-bit instruction):
  - Always emit {L,buf} as 32-bit, pc=fetch_pc-2.
  - full(U): flag f1f2, buf<=U, stay SPLIT.
  - !full(U): flag fh, stall_compressed=1, go to UPPER_C.
- State UPPER_C (same word held by fetch):
  - Emit U compressed, hh, stall_compressed=0, pc=fetch_pc+2, go to ALIGNED.
- State SKIP_LOW (after a redirect to pc[1]=1):
  - full(U): instr_valid=0, all flags 0, buf<=U, go to SPLIT.
  - !full(U): emit U compressed, hh, stall_compressed=0, pc=fetch_pc+2, go to ALIGNED.
- Flush:
  - Next state is SKIP_LOW if flush_pc1, else ALIGNED; buf<=BUF_RST.
  - instr_valid is forced to 0 in the flush cycle.
  - Flush overrides id_ready and fetch_valid.
- Hold conditions:
  - id_ready=0: outputs still reflect the current state. stall_compressed still drives its computed value. No state change.
  - fetch_valid=0: instr_valid=0, stall_compressed=0, flags 0, state holds.
- PC arithmetic is modulo 2^PC_W. fetch_pc=0 in SPLIT gives instr_pc=all-ones-minus-1, with no trap raised here.
- Exactly one flag is high whenever instr_valid=1.
- stall_compressed=1 only with hh (from ALIGNED) or fh.
- A reset mid-sequence discards buf with no emission.

Optional Feature:
- Macro COMPRESSED_EN.
  - Defined: behaviour as above.
  - Undefined: the FSM and buffer are removed. Every valid word is emitted as f1f1 with pc=fetch_pc, is_compressed=0 and stall_compressed=0. flush_pc1 is ignored, and the other four flags are tied 0.

Decomposition:
- Shared package compressed_pkg:
  - typedef enum logic [1:0] align_state_e {ALIGNED, SPLIT, UPPER_C, SKIP_LOW}.
  - typedef struct align_case_t {f1f1, f1f2, hf, fh, hh}.
  - localparam RVC_FULL=2'b11.
- One natural sub-module: rvc_half_classify. It takes a 16-bit half and returns full/compressed; two instances are used, one for L and one for U.

Test Plan:
- Reset, then words 0x00A00093 at pc 0x100 and 0x00B00113 at 0x104 -> two f1f1 emissions at pc 0x100 and 0x104, stall_compressed=0.
- Word 0x45854505 (two c.li) at 0x200 -> cycle 1: instr=0x4505, hh, stall=1, pc 0x200. Cycle 2, same word: instr=0x4585, hh, stall=0, pc 0x202.
- Words 0x00934505 at 0x300 then 0x458500A0 at 0x304:
  - Cycle 1: hf, instr=0x4505, pc 0x300.
  - Cycle 2: fh, instr=0x00A00093, pc 0x302, stall=1.
  - Cycle 3: hh, instr=0x4585, pc 0x306.
- Three consecutive straddled words -> hf, f1f2, f1f2 with instr_pc incrementing by 4 from base+2, with id_ready toggling 0/1 and no state advance while id_ready=0.
- flush with flush_pc1=1, then word 0x00934505 -> no valid in the first cycle, buf=0x0093, state SPLIT. A flush asserted in UPPER_C instead drops the pending upper half.
- Assert reset_n low asynchronously mid-clock while in SPLIT -> instr_valid drops immediately; the next word is treated as ALIGNED.
